reg_scoreboard: RTL and testbench

Issue-stage scoreboard for the dual-issue pipeline's 32×32 register file (4 read ports, 2 write ports). It tracks which architectural registers have an in-flight writer and grants or blocks issue of the master/slave instruction pair on RAW and WAW hazards. It also enforces a cap on outstanding long-latency operations (loads, multiply/divide). Pending state is cleared by the same two write-back ports that write the register file, so the scoreboard and the register file stay consistent under write-back stall.

---
 rtl/cpu_defs_pkg.sv | 22 ++
 rtl/slot_hazard_chk.sv | 60 ++++++
 rtl/reg_scoreboard.sv | 141 ++++++++++++++
 tb/tb_reg_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register address type,
// scoreboard defaults and a one-hot register mask helper.
package cpu_defs_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned MAX_LONG_DEF = 4;

  // One-hot mask for register a; r0 never produces a bit.
  function automatic logic [NUM_REGS-1:0] reg_bit(
    input reg_addr_t a,
    input logic      en
  );
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (en && (a != 5'd0))
      v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/slot_hazard_chk.sv
// Per-slot RAW/WAW/long-cap check for one issue slot.
// SCOREBOARD_FWD_EN: only long producers block RAW.
module slot_hazard_chk
  import cpu_defs_pkg::*;
#(
  parameter int unsigned MAX_LONG = MAX_LONG_DEF
) (
  input  logic [31:0] pend,
  input  logic [31:0] lng,
  input  reg_addr_t   rs,
  input  reg_addr_t   rt,
  input  reg_addr_t   rd,
  input  logic        we,
  input  logic        is_long,
  input  logic [4:0]  long_base,
  input  logic        pair_en,
  input  reg_addr_t   pair_rd,
  output logic        ok
);

  localparam logic [5:0] CAP = 6'(MAX_LONG);

  logic [31:0] raw_mask;
  logic        raw_rs;
  logic        raw_rt;
  logic        waw;
  logic        dep;
  logic [5:0]  long_sum;
  logic        cap_ok;

`ifdef SCOREBOARD_FWD_EN
  assign raw_mask = pend & lng;
`else
  assign raw_mask = pend;
`endif

  // Source/dest hazards against in-flight writers.
  always_comb begin
    raw_rs = (rs != 5'd0) & raw_mask[rs];
    raw_rt = (rt != 5'd0) & raw_mask[rt];
    waw    = we & (rd != 5'd0) & pend[rd];
  end

  // Dependency on the older instruction of the same pair.
  always_comb begin
    dep = pair_en & (
            ((rs != 5'd0) & (rs == pair_rd)) |
            ((rt != 5'd0) & (rt == pair_rd)) |
            ((rd != 5'd0) & (rd == pair_rd)));
  end

  // Outstanding long-latency cap including this slot.
  always_comb begin
    long_sum = {1'b0, long_base} + {5'b0, is_long};
    cap_ok   = (long_sum <= CAP);
  end

  assign ok = ~raw_rs & ~raw_rt & ~waw & ~dep & cap_ok;

endmodule

// File: rtl/reg_scoreboard.sv
// Dual-issue register scoreboard: pending writers, long cap.
// Optional macro SCOREBOARD_FWD_EN: short producers bypass RAW.
module reg_scoreboard
  import cpu_defs_pkg::*;
#(
  parameter int unsigned MAX_LONG = MAX_LONG_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  input  logic        s_valid,
  input  reg_addr_t   m_rs,
  input  reg_addr_t   m_rt,
  input  reg_addr_t   s_rs,
  input  reg_addr_t   s_rt,
  input  reg_addr_t   m_rd,
  input  reg_addr_t   s_rd,
  input  logic        m_we,
  input  logic        s_we,
  input  logic        m_long,
  input  logic        s_long,
  input  logic        id_stall,
  output logic        issue_m,
  output logic        issue_s,
  input  logic        stall_masterW,
  input  logic        we3,
  input  logic        we4,
  input  reg_addr_t   wa3,
  input  reg_addr_t   wa4,
  input  logic        wl3,
  input  logic        wl4,
  input  logic        flush,
  output logic [31:0] busy,
  output logic [3:0]  long_cnt
);

  logic [31:0] pend;
  logic [31:0] lng;
  logic        m_ok;
  logic        s_ok;
  logic [4:0]  s_base;

  assign s_base = {1'b0, long_cnt} + {4'b0, m_long};

  slot_hazard_chk #(.MAX_LONG(MAX_LONG)) u_m_chk (
    .pend      (pend),
    .lng       (lng),
    .rs        (m_rs),
    .rt        (m_rt),
    .rd        (m_rd),
    .we        (m_we),
    .is_long   (m_long),
    .long_base ({1'b0, long_cnt}),
    .pair_en   (1'b0),
    .pair_rd   (5'd0),
    .ok        (m_ok)
  );

  slot_hazard_chk #(.MAX_LONG(MAX_LONG)) u_s_chk (
    .pend      (pend),
    .lng       (lng),
    .rs        (s_rs),
    .rt        (s_rt),
    .rd        (s_rd),
    .we        (s_we),
    .is_long   (s_long),
    .long_base (s_base),
    .pair_en   (m_we),
    .pair_rd   (m_rd),
    .ok        (s_ok)
  );

  assign issue_m = m_valid & ~id_stall & ~rst & m_ok;
  assign issue_s = issue_m & s_valid & s_ok;

  logic [31:0] set_m;
  logic [31:0] set_s;
  logic [31:0] set_v;
  logic [31:0] lset;
  logic [31:0] clr;
  logic        wb3;
  logic        wb4;
  logic [1:0]  inc;
  logic [1:0]  dec;
  logic [5:0]  cnt_sum;
  logic [3:0]  cnt_nxt;
  logic [31:0] pend_nxt;
  logic [31:0] lng_nxt;

  // Set/clear masks from issue and write-back events.
  always_comb begin
    set_m = reg_bit(m_rd, issue_m & m_we);
    set_s = reg_bit(s_rd, issue_s & s_we);
    set_v = set_m | set_s;
    lset  = (m_long ? set_m : 32'd0) |
            (s_long ? set_s : 32'd0);
    wb3   = ~stall_masterW & we3 & (wa3 != 5'd0);
    wb4   = ~stall_masterW & we4 & (wa4 != 5'd0);
    clr   = reg_bit(wa3, wb3) | reg_bit(wa4, wb4);
  end

  // Next pending state; a same-cycle set beats a clear.
  always_comb begin
    pend_nxt = (pend & ~clr) | set_v;
    lng_nxt  = (lng & ~clr & ~set_v) | lset;
    pend_nxt[0] = 1'b0;
    lng_nxt[0]  = 1'b0;
  end

  // Long counter update, saturating at zero on underflow.
  always_comb begin
    inc = {1'b0, |(set_m & lset)} +
          {1'b0, |(set_s & lset)};
    dec = {1'b0, wb4 & wl4} + {1'b0, wb3 & wl3};
    cnt_sum = {2'b00, long_cnt} + {4'b0, inc};
    if (cnt_sum > {4'b0, dec})
      cnt_nxt = 4'(cnt_sum - {4'b0, dec});
    else
      cnt_nxt = 4'd0;
  end

  // State register: reset over flush over normal update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      lng      <= '0;
      long_cnt <= '0;
    end else if (flush) begin
      pend     <= '0;
      lng      <= '0;
      long_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      lng      <= lng_nxt;
      long_cnt <= cnt_nxt;
    end
  end

  assign busy = pend;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard (MAX_LONG=2).
// Directed plan scenarios followed by random traffic.
module tb_reg_scoreboard;
  import cpu_defs_pkg::*;

  localparam int ML = 2;
`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, s_valid;
  reg_addr_t   m_rs, m_rt, s_rs, s_rt, m_rd, s_rd;
  logic        m_we, s_we, m_long, s_long;
  logic        id_stall;
  logic        issue_m, issue_s;
  logic        stall_masterW;
  logic        we3, we4;
  reg_addr_t   wa3, wa4;
  logic        wl3, wl4;
  logic        flush;
  logic [31:0] busy;
  logic [3:0]  long_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] mp = '0;
  logic [31:0] ml = '0;
  int          mc = 0;

  reg_scoreboard #(.MAX_LONG(ML)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .s_valid(s_valid),
    .m_rs(m_rs), .m_rt(m_rt), .s_rs(s_rs), .s_rt(s_rt),
    .m_rd(m_rd), .s_rd(s_rd),
    .m_we(m_we), .s_we(s_we),
    .m_long(m_long), .s_long(s_long),
    .id_stall(id_stall),
    .issue_m(issue_m), .issue_s(issue_s),
    .stall_masterW(stall_masterW),
    .we3(we3), .we4(we4), .wa3(wa3), .wa4(wa4),
    .wl3(wl3), .wl4(wl4),
    .flush(flush),
    .busy(busy), .long_cnt(long_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit raw_blk(input reg_addr_t r);
    return (r != 0) && mp[r] && (!FWD || ml[r]);
  endfunction

  function automatic bit exp_m();
    return m_valid && !id_stall && !rst &&
           !raw_blk(m_rs) && !raw_blk(m_rt) &&
           !(m_we && m_rd != 0 && mp[m_rd]) &&
           !(m_long && mc == ML);
  endfunction

  function automatic bit exp_s(input bit em);
    bit dep;
    dep = m_we && ((s_rs != 0 && s_rs == m_rd) ||
                   (s_rt != 0 && s_rt == m_rd) ||
                   (s_rd != 0 && s_rd == m_rd));
    return em && s_valid &&
           !raw_blk(s_rs) && !raw_blk(s_rt) &&
           !(s_we && s_rd != 0 && mp[s_rd]) && !dep &&
           (mc + int'(m_long) + int'(s_long) <= ML);
  endfunction

  // Mid-cycle compare against the model, then advance it.
  always @(negedge clk) begin
    bit em, es;
    int dec;
    em = exp_m();
    es = exp_s(em);
    chk("issue_m", {31'b0, issue_m}, {31'b0, em});
    chk("issue_s", {31'b0, issue_s}, {31'b0, es});
    chk("busy", busy, mp);
    chk("long_cnt", {28'b0, long_cnt}, 32'(mc));
    chk("cnt_cap", {31'b0, long_cnt > ML}, 32'd0);
    if (rst || flush) begin
      mp = '0; ml = '0; mc = 0;
    end else begin
      dec = 0;
      if (!stall_masterW && we3 && wa3 != 0) begin
        mp[wa3] = 1'b0; ml[wa3] = 1'b0;
        if (wl3) dec++;
      end
      if (!stall_masterW && we4 && wa4 != 0) begin
        mp[wa4] = 1'b0; ml[wa4] = 1'b0;
        if (wl4) dec++;
      end
      mc = (mc > dec) ? mc - dec : 0;
      if (em && m_we && m_rd != 0) begin
        mp[m_rd] = 1'b1; ml[m_rd] = m_long;
        if (m_long) mc++;
      end
      if (es && s_we && s_rd != 0) begin
        mp[s_rd] = 1'b1; ml[s_rd] = s_long;
        if (s_long) mc++;
      end
    end
  end

  task automatic clr_in();
    m_valid = 0; s_valid = 0;
    m_rs = 0; m_rt = 0; s_rs = 0; s_rt = 0;
    m_rd = 0; s_rd = 0;
    m_we = 0; s_we = 0; m_long = 0; s_long = 0;
    id_stall = 0; stall_masterW = 0;
    we3 = 0; we4 = 0; wa3 = 0; wa4 = 0;
    wl3 = 0; wl4 = 0; flush = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int q[$];
    int k;
    rst = 1'b1;
    clr_in();
    m_valid = 1; m_rd = 1; m_we = 1;
    settle();
    chk("rst_issue", {31'b0, issue_m}, 32'd0);
    nxt(); nxt();
    chk("rst_busy", busy, 32'd0);
    chk("rst_cnt", {28'b0, long_cnt}, 32'd0);

    // RAW on a short producer
    rst = 0; clr_in();
    m_valid = 1; m_rd = 5; m_we = 1;
    settle();
    chk("t1_prod", {31'b0, issue_m}, 32'd1);
    nxt();
    chk("t1_busy", busy, 32'h20);
    clr_in(); m_valid = 1; m_rs = 5;
    settle();
    chk("t1_raw", {31'b0, issue_m}, {31'b0, FWD});
    nxt();
    we3 = 1; wa3 = 5;
    settle();
    chk("t1_wbcyc", {31'b0, issue_m}, {31'b0, FWD});
    nxt();
    we3 = 0; wa3 = 0;
    settle();
    chk("t1_after", {31'b0, issue_m}, 32'd1);
    chk("t1_clr", busy, 32'd0);
    nxt();

    // Intra-pair dependency
    clr_in();
    m_valid = 1; m_rd = 7; m_we = 1;
    s_valid = 1; s_rs = 7;
    settle();
    chk("t2_m", {31'b0, issue_m}, 32'd1);
    chk("t2_s", {31'b0, issue_s}, 32'd0);
    nxt();
    clr_in(); we3 = 1; wa3 = 7;
    nxt();
    clr_in(); m_valid = 1; m_rs = 7;
    settle();
    chk("t2_reissue", {31'b0, issue_m}, 32'd1);
    nxt();

    // Long-latency cap
    clr_in(); m_valid = 1; m_we = 1; m_long = 1; m_rd = 10;
    nxt();
    m_rd = 11;
    nxt();
    m_rd = 12;
    settle();
    chk("t3_cnt2", {28'b0, long_cnt}, 32'd2);
    chk("t3_block", {31'b0, issue_m}, 32'd0);
    nxt();
    we4 = 1; wa4 = 10; wl4 = 1;
    settle();
    chk("t3_block2", {31'b0, issue_m}, 32'd0);
    nxt();
    we4 = 0; wa4 = 0; wl4 = 0;
    settle();
    chk("t3_cnt1", {28'b0, long_cnt}, 32'd1);
    chk("t3_go", {31'b0, issue_m}, 32'd1);
    nxt();
    clr_in();
    we3 = 1; wa3 = 11; wl3 = 1;
    we4 = 1; wa4 = 12; wl4 = 1;
    nxt();
    clr_in();
    settle();
    chk("t3_drain", {28'b0, long_cnt}, 32'd0);
    chk("t3_busy", busy, 32'd0);

    // Write-back stall
    m_valid = 1; m_we = 1; m_rd = 9;
    nxt();
    clr_in(); stall_masterW = 1; we3 = 1; wa3 = 9;
    nxt();
    chk("t4_hold", {31'b0, busy[9]}, 32'd1);
    stall_masterW = 0;
    nxt();
    chk("t4_clr", {31'b0, busy[9]}, 32'd0);

    // r0 and counter underflow
    clr_in(); m_valid = 1; m_we = 1; m_rd = 0;
    we4 = 1; wa4 = 0;
    nxt();
    chk("t5_busy", busy, 32'd0);
    chk("t5_cnt", {28'b0, long_cnt}, 32'd0);
    clr_in(); we3 = 1; wa3 = 4; wl3 = 1;
    nxt();
    chk("t5_under", {28'b0, long_cnt}, 32'd0);

    // Flush with a simultaneous issue
    clr_in();
    m_valid = 1; m_we = 1; m_long = 1; m_rd = 3;
    s_valid = 1; s_we = 1; s_long = 1; s_rd = 12;
    nxt();
    clr_in();
    chk("t6_busy", busy, 32'h1008);
    chk("t6_cnt", {28'b0, long_cnt}, 32'd2);
    flush = 1; m_valid = 1; m_we = 1; m_rd = 20;
    nxt();
    clr_in();
    chk("t6_fbusy", busy, 32'd0);
    chk("t6_fcnt", {28'b0, long_cnt}, 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 99) == 0);
      id_stall = ($urandom_range(0, 7) == 0);
      stall_masterW = ($urandom_range(0, 5) == 0);
      m_valid = ($urandom_range(0, 3) != 0);
      s_valid = ($urandom_range(0, 2) != 0);
      m_rs = 5'($urandom_range(0, 7));
      m_rt = 5'($urandom_range(0, 7));
      m_rd = 5'($urandom_range(0, 7));
      s_rs = 5'($urandom_range(0, 7));
      s_rt = 5'($urandom_range(0, 7));
      s_rd = 5'($urandom_range(0, 7));
      m_we = $urandom_range(0, 1);
      s_we = $urandom_range(0, 1);
      m_long = ($urandom_range(0, 3) == 0);
      s_long = ($urandom_range(0, 3) == 0);
      q.delete();
      for (int r = 1; r < 32; r++)
        if (mp[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q.size() - 1);
        we3 = 1; wa3 = 5'(q[k]); wl3 = ml[q[k]];
        q.delete(k);
      end
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, q.size() - 1);
        we4 = 1; wa4 = 5'(q[k]); wl4 = ml[q[k]];
      end
      nxt();
    end
    rst = 0;
    clr_in();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
